// File: rtl/burst_rw_sched_pkg.sv
// burst_rw_sched_pkg
//   Command-type encodings shared by the CAS stage, the scheduler and the
//   burst data stage. 2'b00 is reserved to mean "no burst" on rw_type, and
//   2'b11 is illegal on rw_request.
package burst_rw_sched_pkg;
   localparam logic [1:0] READ  = 2'b01;
   localparam logic [1:0] WRITE = 2'b10;
endpackage

// File: rtl/burst_rw_sched.sv
// burst_rw_sched
//   Latency scheduler between the CAS command stage and the burst data stage.
//   Each accepted CAS is parked in a small in-flight table with a countdown
//   and an age stamp. A one-cycle burst-start command (rw_cmd/rw_type/rw_data)
//   is emitted exactly RD_DELAY or WR_DELAY clocks after the accepting edge.
//
// Ports
//   clock_t      rising-edge DDR clock
//   reset_n      asynchronous active-low reset
//   cas_cmd      CAS issued this cycle (taken only while cas_ready=1)
//   rw_request   READ / WRITE from burst_rw_sched_pkg
//   data_in      write data sampled with cas_cmd
//   rd_delay     read latency in clocks (quasi-static)
//   wr_delay     write latency in clocks (quasi-static)
//   cas_ready    a table entry is free
//   rw_cmd       one-cycle burst-start pulse
//   rw_type      type of the issued burst, 2'b00 when idle
//   rw_data      write data of the issued burst, 0 for reads and idle
//   burst_busy   data bus occupied, BURST_CLKS cycles from rw_cmd
//   ovf_err      sticky: CAS dropped (table full or illegal request)
//   overlap_err  sticky: burst start collided with another due entry or
//                with a burst still on the bus
//
// Handshake: a CAS transfers on a rising edge where cas_cmd=1 and
// cas_ready=1; cas_ready depends on registered state only. rw_cmd has no
// back-pressure: the burst data stage must take it in the cycle it is high.
module burst_rw_sched
   import burst_rw_sched_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int DATA_W     = 64,
   parameter int DLY_W      = 6,
   parameter int BURST_CLKS = 4
) (
   input  logic              clock_t,
   input  logic              reset_n,
   input  logic              cas_cmd,
   input  logic [1:0]        rw_request,
   input  logic [DATA_W-1:0] data_in,
   input  logic [DLY_W-1:0]  rd_delay,
   input  logic [DLY_W-1:0]  wr_delay,
   output logic              cas_ready,
   output logic              rw_cmd,
   output logic [1:0]        rw_type,
   output logic [DATA_W-1:0] rw_data,
   output logic              burst_busy,
   output logic              ovf_err,
   output logic              overlap_err
);

   localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int AW  = DLY_W + 1;
   localparam int BCW = $clog2(BURST_CLKS + 1);

   // in-flight table
   logic [DEPTH-1:0]  valid;
   logic [1:0]        ent_type [DEPTH];
   logic [DATA_W-1:0] ent_data [DEPTH];
   logic [DLY_W-1:0]  ent_cnt  [DEPTH];
   logic [AW-1:0]     ent_age  [DEPTH];
   logic [AW-1:0]     age_ctr;
   logic [BCW-1:0]    burst_cnt;

   // selection / allocation
   logic [AW-1:0]     rel_age [DEPTH];
   logic [DEPTH-1:0]  due;
   logic [DEPTH-1:0]  issue_vec;
   logic              sel_found;
   logic [IW-1:0]     sel_idx;
   logic [AW-1:0]     sel_rel;
   logic              multi_due;
   logic              free_found;
   logic [IW-1:0]     free_idx;
   logic              legal_req;
   logic              accept;
   logic [DLY_W-1:0]  d_sel;
   logic [DLY_W-1:0]  d_start;
   logic              collide;

   assign cas_ready  = ~&valid;
   assign burst_busy = (burst_cnt != '0);

   assign legal_req = (rw_request == READ) || (rw_request == WRITE);
   assign accept    = cas_cmd && cas_ready && legal_req;
   assign d_sel     = (rw_request == WRITE) ? wr_delay : rd_delay;
   // Clamp to 2 so a new entry is never due in the cycle it is accepted.
   assign d_start   = (d_sel < DLY_W'(2)) ? DLY_W'(2) : d_sel;

   // Oldest-first pick among due entries. age_ctr is the next stamp to hand
   // out, so age_ctr - stamp is larger for older entries; with at most DEPTH
   // live entries this modular distance never wraps.
   always_comb begin
      due       = '0;
      issue_vec = '0;
      sel_found = 1'b0;
      sel_idx   = '0;
      sel_rel   = '0;
      multi_due = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         rel_age[i] = age_ctr - ent_age[i];
         due[i]     = valid[i] && (ent_cnt[i] == DLY_W'(1));
         if (due[i]) begin
            if (sel_found) multi_due = 1'b1;
            if (!sel_found || (rel_age[i] > sel_rel)) begin
               sel_found = 1'b1;
               sel_idx   = i[IW-1:0];
               sel_rel   = rel_age[i];
            end
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         issue_vec[i] = sel_found && (sel_idx == i[IW-1:0]);
      end
   end

   // lowest-index free entry
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!valid[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = i[IW-1:0];
         end
      end
   end

   // A new burst collides if another entry was also due, or if the previous
   // burst still occupies the bus in the cycle the new rw_cmd is high
   // (counter above 1 here means it will still be non-zero next cycle).
   assign collide = sel_found && (multi_due || (burst_cnt > BCW'(1)));

   always_ff @(posedge clock_t or negedge reset_n) begin
      if (!reset_n) begin
         valid       <= '0;
         age_ctr     <= '0;
         burst_cnt   <= '0;
         rw_cmd      <= 1'b0;
         rw_type     <= 2'b00;
         rw_data     <= '0;
         ovf_err     <= 1'b0;
         overlap_err <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_type[i] <= 2'b00;
            ent_data[i] <= '0;
            ent_cnt[i]  <= '0;
            ent_age[i]  <= '0;
         end
      end else begin
         // Countdown; a due entry that lost arbitration parks at 1.
         for (int i = 0; i < DEPTH; i++) begin
            if (issue_vec[i]) begin
               valid[i] <= 1'b0;
            end else if (valid[i] && (ent_cnt[i] != DLY_W'(1))) begin
               ent_cnt[i] <= ent_cnt[i] - DLY_W'(1);
            end
         end

         if (sel_found) begin
            rw_cmd  <= 1'b1;
            rw_type <= ent_type[sel_idx];
            rw_data <= ent_data[sel_idx];
         end else begin
            rw_cmd  <= 1'b0;
            rw_type <= 2'b00;
            rw_data <= '0;
         end

         // The free slot is never the issuing slot, so both can happen.
         if (accept) begin
            valid[free_idx]    <= 1'b1;
            ent_type[free_idx] <= rw_request;
            ent_data[free_idx] <= (rw_request == WRITE) ? data_in : '0;
            ent_cnt[free_idx]  <= d_start;
            ent_age[free_idx]  <= age_ctr;
            age_ctr            <= age_ctr + AW'(1);
         end

         if (sel_found) begin
            burst_cnt <= BCW'(BURST_CLKS);
         end else if (burst_cnt != '0) begin
            burst_cnt <= burst_cnt - BCW'(1);
         end

         if (cas_cmd && !accept) ovf_err <= 1'b1;
         if (collide) overlap_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_burst_rw_sched.sv
// tb_burst_rw_sched
//   Directed bench for burst_rw_sched. Every CAS that should produce a burst
//   pushes {expected issue edge, type, data} to exp_q; a negedge monitor pops
//   and compares on each rw_cmd pulse. Any pulse with an empty queue, or any
//   entry left in the queue at the end, is an error.
module tb_burst_rw_sched;
   import burst_rw_sched_pkg::*;

   localparam int DATA_W = 64;
   localparam int DLY_W  = 6;
   localparam int W      = 32 + 2 + DATA_W;

   logic              clock_t;
   logic              reset_n;
   logic              cas_cmd;
   logic [1:0]        rw_request;
   logic [DATA_W-1:0] data_in;
   logic [DLY_W-1:0]  rd_delay;
   logic [DLY_W-1:0]  wr_delay;
   logic              cas_ready;
   logic              rw_cmd;
   logic [1:0]        rw_type;
   logic [DATA_W-1:0] rw_data;
   logic              burst_busy;
   logic              ovf_err;
   logic              overlap_err;

   int n_cmp = 0;
   int n_err = 0;
   int edge_n = 0;
   logic [W-1:0] exp_q[$];
   logic [DATA_W-1:0] wdata;

   burst_rw_sched #(
      .DEPTH(4), .DATA_W(DATA_W), .DLY_W(DLY_W), .BURST_CLKS(4)
   ) dut (
      .clock_t    (clock_t),
      .reset_n    (reset_n),
      .cas_cmd    (cas_cmd),
      .rw_request (rw_request),
      .data_in    (data_in),
      .rd_delay   (rd_delay),
      .wr_delay   (wr_delay),
      .cas_ready  (cas_ready),
      .rw_cmd     (rw_cmd),
      .rw_type    (rw_type),
      .rw_data    (rw_data),
      .burst_busy (burst_busy),
      .ovf_err    (ovf_err),
      .overlap_err(overlap_err)
   );

   // ---------------- clock / edge counter ----------------
   initial clock_t = 1'b0;
   always #5 clock_t = ~clock_t;
   always @(posedge clock_t) edge_n <= edge_n + 1;

   // ---------------- checker ----------------
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Called at a negedge; the CAS is sampled on the next posedge (edge_n+1).
   task automatic drive_cas(input logic [1:0] t, input logic [DATA_W-1:0] d,
                            input bit push, input int dly);
      cas_cmd    = 1'b1;
      rw_request = t;
      data_in    = d;
      if (push)
         exp_q.push_back({32'(edge_n + 1 + dly), t, (t == WRITE) ? d : {DATA_W{1'b0}}});
      @(negedge clock_t);
      cas_cmd    = 1'b0;
      rw_request = 2'b00;
      data_in    = '0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clock_t);
      reset_n = 1'b1;
      exp_q.delete();
      @(negedge clock_t);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clock_t) begin
      logic [W-1:0] item;
      if (rw_cmd === 1'b1) begin
         chk("rw_cmd_expected", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) begin
            item = exp_q.pop_front();
            chk("issue_edge", edge_n, item[W-1 -: 32]);
            chk("issue_type", rw_type, item[DATA_W +: 2]);
            chk("issue_data", rw_data, item[DATA_W-1:0]);
            chk("busy_with_cmd", burst_busy, 1'b1);
         end
      end else if (reset_n === 1'b1) begin
         chk("idle_type", rw_type, 2'b00);
         chk("idle_data", rw_data, {DATA_W{1'b0}});
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin
      reset_n    = 1'b0;
      cas_cmd    = 1'b0;
      rw_request = 2'b00;
      data_in    = '0;
      rd_delay   = 6'd5;
      wr_delay   = 6'd3;
      repeat (3) @(negedge clock_t);
      chk("rst_cas_ready", cas_ready, 1'b1);
      chk("rst_rw_cmd", rw_cmd, 1'b0);
      chk("rst_rw_type", rw_type, 2'b00);
      chk("rst_rw_data", rw_data, {DATA_W{1'b0}});
      chk("rst_busy", burst_busy, 1'b0);
      chk("rst_ovf", ovf_err, 1'b0);
      chk("rst_overlap", overlap_err, 1'b0);
      reset_n = 1'b1;
      @(negedge clock_t);

      // single read, D=5; read data must come out as 0
      drive_cas(READ, 64'hDEAD_BEEF_0123_4567, 1, 5);
      repeat (5) @(negedge clock_t);
      chk("t1_rw_cmd", rw_cmd, 1'b1);
      chk("t1_rw_type", rw_type, READ);
      for (int i = 0; i < 4; i++) begin
         chk("t1_busy_on", burst_busy, 1'b1);
         @(negedge clock_t);
      end
      chk("t1_busy_off", burst_busy, 1'b0);
      chk("t1_rw_cmd_one_cycle", rw_cmd, 1'b0);

      // write passthrough, D=3
      drive_cas(WRITE, 64'hFFEEDDCCBBAA7766, 1, 3);
      repeat (3) @(negedge clock_t);
      chk("t2_rw_data", rw_data, 64'hFFEEDDCCBBAA7766);
      repeat (5) @(negedge clock_t);
      chk("t2_overlap", overlap_err, 1'b0);

      // delay 1 clamps to 2; bursts spaced exactly BURST_CLKS apart
      rd_delay = 6'd1;
      drive_cas(READ, {$urandom, $urandom}, 1, 2);
      repeat (3) @(negedge clock_t);
      drive_cas(READ, {$urandom, $urandom}, 1, 2);
      repeat (8) @(negedge clock_t);
      chk("t5_overlap", overlap_err, 1'b0);
      chk("t5_ovf", ovf_err, 1'b0);

      // collision: READ D=6 then WRITE D=4 two clocks later, both due together;
      // the older READ goes first, the WRITE slips one clock
      rd_delay = 6'd6;
      wr_delay = 6'd4;
      wdata = {$urandom, $urandom};
      drive_cas(READ, {$urandom, $urandom}, 1, 6);
      @(negedge clock_t);
      drive_cas(WRITE, wdata, 1, 5);
      repeat (12) @(negedge clock_t);
      chk("t4_overlap", overlap_err, 1'b1);

      // reset clears sticky flags; illegal request drops the CAS
      do_reset();
      chk("rst2_overlap", overlap_err, 1'b0);
      drive_cas(2'b11, {$urandom, $urandom}, 0, 0);
      chk("illegal_ovf", ovf_err, 1'b1);
      chk("illegal_ready", cas_ready, 1'b1);
      repeat (10) @(negedge clock_t);

      // fill / overflow with D=20
      do_reset();
      chk("rst3_ovf", ovf_err, 1'b0);
      rd_delay = 6'd20;
      for (int i = 0; i < 4; i++) drive_cas(READ, {$urandom, $urandom}, 1, 20);
      chk("t3_full_ready", cas_ready, 1'b0);
      drive_cas(READ, {$urandom, $urandom}, 0, 0);
      chk("t3_ovf", ovf_err, 1'b1);
      repeat (25) @(negedge clock_t);
      chk("t3_overlap", overlap_err, 1'b1);
      chk("t3_ready_back", cas_ready, 1'b1);

      // reset mid-flight: pending entries must vanish
      for (int i = 0; i < 3; i++) drive_cas(READ, {$urandom, $urandom}, 0, 0);
      chk("t6_pending_ready", cas_ready, 1'b1);
      reset_n = 1'b0;
      @(negedge clock_t);
      reset_n = 1'b1;
      chk("t6_ready", cas_ready, 1'b1);
      chk("t6_ovf", ovf_err, 1'b0);
      chk("t6_overlap", overlap_err, 1'b0);
      repeat (30) @(negedge clock_t);
      chk("t6_busy", burst_busy, 1'b0);

      chk("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/burst_rw_sched.md
Name: burst_rw_sched

Overview:
- Latency scheduler between the CAS command stage and the burst data stage.
- Captures each issued CAS (read or write, plus write data) and holds it in a small in-flight table.
- Emits a one-cycle burst-start command (rw_cmd with type and data) exactly RD_DELAY/WR_DELAY clocks after the CAS was accepted, which the burst data stage consumes to drive DQ/DQS.
- Flags table overflow and data-bus burst collisions.

Parameters:
- DEPTH, 4, number of in-flight CAS entries (2..8).
- DATA_W, 64, width of the burst write-data word.
- DLY_W, 6, width of the delay inputs and per-entry countdown.
- BURST_CLKS, 4, clocks one burst occupies on the data bus (BL8/2).

Ports:
- clock_t  input  1  rising-edge clock, the true DDR clock.
- reset_n  input  1  asynchronous active-low reset.
- cas_cmd  input  1  CAS issued this cycle; qualified by cas_ready.
- rw_request  input  2  package READ or WRITE constant; other values illegal.
- data_in  input  DATA_W  write data, sampled with cas_cmd.
- rd_delay  input  DLY_W  read latency in clocks (CL+AL); quasi-static.
- wr_delay  input  DLY_W  write latency in clocks (CWL+AL); quasi-static.
- cas_ready  output  1  high when an entry is free.
- rw_cmd  output  1  one-cycle burst-start pulse.
- rw_type  output  2  READ/WRITE of the issued burst; 2'b00 when idle.
- rw_data  output  DATA_W  write data of the issued burst; 0 for reads and when idle.
- burst_busy  output  1  high for BURST_CLKS cycles starting with rw_cmd.
- ovf_err  output  1  sticky; a CAS was presented while full, or with an illegal rw_request.
- overlap_err  output  1  sticky; a burst start collided with another due entry or an active burst.

Behaviour:
Reset (asynchronous assert, synchronous release):
- All entries become invalid.
- cas_ready=1; rw_cmd=0, rw_type=0, rw_data=0, burst_busy=0, ovf_err=0, overlap_err=0.
- Asserting reset mid-operation discards all pending entries; no rw_cmd is issued for them.

Accept:
- A CAS is accepted at edge k when cas_cmd=1 and cas_ready=1 and rw_request is READ or WRITE.
- The accepted CAS is written to the lowest-index free entry with: type; data (data_in for WRITE, 0 for READ); count = selected delay; and an age stamp.
- A selected delay below 2 is clamped to 2.
- Any other cas_cmd=1 presentation (table full, or illegal rw_request) drops the CAS and sets ovf_err.

Countdown and issue:
- Every valid entry decrements its count each clock.
- An entry with count==1 at edge k+D-1 is "due". Due entries are issued registered, so rw_cmd is high in the cycle following edge k+D.
- Net latency: rw_cmd appears exactly D clocks after the accepting edge.

cas_ready and occupancy:
- cas_ready = (valid count < DEPTH), derived from registered state only.
- An entry freed by issue at edge n is available from cycle n+1. There is no same-cycle bypass when full.

Collisions:
- If more than one entry is due in the same cycle, the oldest (smallest age) issues and overlap_err is set.
- Each non-selected due entry holds count at 1 and issues in a later cycle, oldest first.
- If an entry issues while burst_busy=1, it still issues, overlap_err is set, and the burst counter reloads to BURST_CLKS.

Burst counter:
- rw_cmd loads the counter with BURST_CLKS.
- burst_busy = (counter != 0); the counter decrements each clock.

Age stamp:
- The age stamp is a DLY_W+1-bit wrap-around accept counter.
- Age comparison uses modular subtraction, valid because at most DEPTH entries are live.

Simultaneous events:
- Accept and issue in the same cycle are both performed.
- A newly accepted entry is never due in its accept cycle.
- ovf_err and overlap_err clear only on reset.

Test Plan:
- Single read: rd_delay=5, cas_cmd/READ accepted at edge 10 -> rw_cmd=1, rw_type=READ in cycle after edge 15; burst_busy high 4 cycles; rw_data=0.
- Write passthrough: wr_delay=3, WRITE with data_in=64'hFFEEDDCCBBAA7766 at edge 20 -> rw_cmd after edge 23, rw_data=64'hFFEEDDCCBBAA7766, overlap_err=0.
- Fill/overflow: DEPTH=4, rd_delay=20, five consecutive READ CAS -> cas_ready low after 4th accept, 5th dropped, ovf_err=1, exactly four rw_cmd pulses spaced 1 clock (overlap_err=1).
- Collision ordering: READ (rd_delay=6) at edge 0, WRITE (wr_delay=4) at edge 2 -> both due at edge 6; READ issues after edge 6, WRITE after edge 7, overlap_err=1.
- Clamp and spacing: rd_delay=1, READs at edges 0 and 4 -> rw_cmd after edges 2 and 6, no overlap_err (spacing = BURST_CLKS).
- Reset mid-flight: three entries pending, reset_n low for 1 cycle -> no rw_cmd afterwards, cas_ready=1, all error flags 0.
